// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and helpers for the stream round-robin arbiter
package stream_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } out_state_t;

  // Increment with wrap for index spaces that need not be a power of two.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = IDX_W'(next_ptr(32'(cand), NUM_REQ));
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-granular round-robin mux of NUM_REQ streams into one registered output
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  WORD_WIDTH = 8,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WORD_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [SRC_W-1:0]              m_src
);

  arb_state_t             arb_q, arb_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic [SRC_W-1:0]       gnt_q, gnt_d;
  out_state_t             out_q, out_d;
  logic                   m_valid_q, stage_rdy_q;

  logic [WORD_WIDTH-1:0]  main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                   main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic [SRC_W-1:0]       main_src_q, main_src_d, skid_src_q, skid_src_d;

  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [SRC_W-1:0]       sel_idx;
  logic                   in_fire;
  logic [WORD_WIDTH-1:0]  in_data;
  logic                   in_last;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    return SRC_W'(next_ptr(32'(idx), NUM_REQ));
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (s_valid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign sel_idx = (arb_q == ARB_LOCK) ? gnt_q : pick_idx;
  assign in_fire = |(s_valid & s_ready);
  assign in_data = s_data[sel_idx*WORD_WIDTH +: WORD_WIDTH];
  assign in_last = s_last[sel_idx];

  // Arbiter FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arb_q <= ARB_IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
    end else begin
      arb_q <= arb_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

  // Arbiter FSM: next state
  always_comb begin
    arb_d = arb_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    case (arb_q)
      ARB_IDLE: begin
        if (in_fire) begin
          if (in_last) begin
            ptr_d = wrap_inc(pick_idx);
          end else begin
            arb_d = ARB_LOCK;
            gnt_d = pick_idx;
          end
        end
      end
      ARB_LOCK: begin
        if (in_fire && in_last) begin
          arb_d = ARB_IDLE;
          ptr_d = wrap_inc(gnt_q);
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  // Arbiter FSM: outputs; a locked owner keeps its ready even while its valid is low
  always_comb begin
    s_ready = '0;
    if (rstn) begin
      if (arb_q == ARB_LOCK) begin
        s_ready[gnt_q] = stage_rdy_q;
      end else if (pick_vld) begin
        s_ready[pick_idx] = stage_rdy_q;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    case (out_q)
      EMPTY: if (in_fire) out_d = BUSY;
      BUSY: begin
        if (in_fire && !m_ready) begin
          out_d = FULL;
        end else if (!in_fire && m_ready) begin
          out_d = EMPTY;
        end
      end
      FULL: if (m_ready) out_d = BUSY;
      default: out_d = EMPTY;
    endcase
  end

  always_comb begin
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_src_d  = skid_src_q;
    if (in_fire && (out_q == EMPTY || (out_q == BUSY && m_ready))) begin
      main_data_d = in_data;
      main_last_d = in_last;
      main_src_d  = sel_idx;
    end else if (out_q == FULL && m_ready) begin
      main_data_d = skid_data_q;
      main_last_d = skid_last_q;
      main_src_d  = skid_src_q;
    end
    if (in_fire && out_q == BUSY && !m_ready) begin
      skid_data_d = in_data;
      skid_last_d = in_last;
      skid_src_d  = sel_idx;
    end
  end

  // Flags are registered from the next state so both m_valid and the upstream ready are flop outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q       <= EMPTY;
      m_valid_q   <= 1'b0;
      stage_rdy_q <= 1'b1;
    end else begin
      out_q       <= out_d;
      m_valid_q   <= (out_d != EMPTY);
      stage_rdy_q <= (out_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_data_q <= '0;
      main_last_q <= 1'b0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_src_q  <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_src_q  <= skid_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = main_data_q;
  assign m_last  = main_last_q;
  assign m_src   = main_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter against a queue-level model
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_t;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_last;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic [1:0]     m_src;

  stream_rr_arbiter #(
    .NUM_REQ    (N),
    .WORD_WIDTH (W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_src   (m_src)
  );

  int checks = 0;
  int errors = 0;

  tx_t    txq [N][$];
  tx_t    rexp [N][$];
  logic [N-1:0] gap;
  beat_t  xlog [$];
  beat_t  exp_q [$];
  beat_t  mq [$];
  int     owner = -1;
  int     rr = 0;
  int     t2_src [5] = '{0, 1, 2, 3, 0};
  int     t2_dat [5] = '{16, 17, 18, 19, 16};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the output stage is a 2-deep FIFO; the arbiter is an owner id plus a rr pointer
  always @(negedge clk) begin : cmp
    logic [N-1:0] er;
    logic         found;
    if (!rstn) begin
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_fields", {21'd0, m_data, m_last, m_src}, 32'd0);
      mq.delete();
      owner = -1;
      rr = 0;
    end else begin
      er = '0;
      found = 1'b0;
      if (owner >= 0) begin
        er[owner] = (mq.size() < 2);
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!found && s_valid[(rr + k) % N]) begin
            found = 1'b1;
            er[(rr + k) % N] = (mq.size() < 2);
          end
        end
      end
      chk("cmp_s_ready", 32'(s_ready), 32'(er));
      chk("cmp_m_valid", 32'(m_valid), 32'(mq.size() > 0));
      if (mq.size() > 0)
        chk("cmp_m_beat", 32'({m_data, m_last, m_src}), 32'(mq[0]));
      if (m_valid && m_ready) xlog.push_back('{m_data, m_last, m_src});
      if (mq.size() > 0 && m_ready) void'(mq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && er[i]) begin
          mq.push_back('{s_data[i*W +: W], s_last[i], 2'(i)});
          if (owner < 0) begin
            if (s_last[i]) rr = (i + 1) % N;
            else owner = i;
          end else if (s_last[i]) begin
            owner = -1;
            rr = (i + 1) % N;
          end
        end
      end
    end
  end

  // Requester driver: holds each head beat until accepted; gap[i] suppresses valid
  initial begin : drv
    logic [N-1:0] acc;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    forever begin
      @(negedge clk);
      acc = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (txq[i].size() > 0 && !gap[i]) begin
          s_valid[i]         = 1'b1;
          s_data[i*W +: W]   = txq[i][0].data;
          s_last[i]          = txq[i][0].last;
        end else begin
          s_valid[i]         = 1'b0;
          s_data[i*W +: W]   = '0;
          s_last[i]          = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    txq[i].push_back('{d, l});
  endtask

  task automatic expb(input logic [7:0] d, input logic l, input int s);
    exp_q.push_back('{d, l, 2'(s)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_tx;
    for (int i = 0; i < N; i++) txq[i].delete();
    gap = '0;
  endtask

  task automatic drain(input string nm);
    bit done;
    m_ready = 1'b1;
    gap = '0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick;
      done = all_empty() && !m_valid;
    end
    chk({nm, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, 32'(xlog.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < xlog.size(); j++)
      chk({nm, "_beat"}, 32'(xlog[j]), 32'(exp_q[j]));
    xlog.delete();
    exp_q.delete();
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    clear_tx();
    tick;
    rstn = 1'b1;
    xlog.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : test
    int npush;
    rstn = 1'b1;
    m_ready = 1'b0;
    gap = '0;
    #1 rstn = 1'b0;
    repeat (3) tick;
    rstn = 1'b1;

    // single beat: same-cycle ready, next-cycle output
    m_ready = 1'b1;
    push(0, 8'hA5, 1'b1);
    tick;
    chk("t1_s_ready", 32'(s_ready), 32'h1);
    tick;
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data", 32'(m_data), 32'hA5);
    chk("t1_m_src", 32'(m_src), 32'd0);
    chk("t1_m_last", 32'(m_last), 32'd1);
    expb(8'hA5, 1'b1, 0);
    drain("t1");
    check_log("t1");

    // four single-beat requesters from ptr=0, no bubbles
    do_reset();
    for (int i = 0; i < N; i++) push(i, 8'(16 + i), 1'b1);
    push(0, 8'h10, 1'b1);
    tick;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t2_m_valid", 32'(m_valid), 32'd1);
      chk("t2_m_src", 32'(m_src), 32'(t2_src[k]));
      chk("t2_m_data", 32'(m_data), 32'(t2_dat[k]));
      expb(8'(t2_dat[k]), 1'b1, t2_src[k]);
    end
    drain("t2");
    check_log("t2");

    // multi-beat packet from 2 is contiguous while 1 waits
    push(1, 8'h30, 1'b1);
    drain("t3a");
    xlog.delete();
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    push(1, 8'h31, 1'b1);
    expb(8'h20, 1'b0, 2);
    expb(8'h21, 1'b0, 2);
    expb(8'h22, 1'b1, 2);
    expb(8'h31, 1'b1, 1);
    drain("t3");
    check_log("t3");

    // backpressure: stage fills, ready drops, head holds
    for (int j = 0; j < 8; j++) begin
      push(0, 8'(8'h40 + j), j == 7);
      expb(8'(8'h40 + j), j == 7, 0);
    end
    repeat (4) tick;
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("t4_m_data_hold", 32'(m_data), 32'h42);
      chk("t4_m_valid_hold", 32'(m_valid), 32'd1);
      chk("t4_s_ready_full", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    drain("t4");
    check_log("t4");

    // owner drops valid mid-packet; lock holds against requester 0
    for (int j = 0; j < 4; j++) begin
      push(3, 8'(8'h50 + j), j == 3);
      expb(8'(8'h50 + j), j == 3, 3);
    end
    push(0, 8'h60, 1'b1);
    expb(8'h60, 1'b1, 0);
    tick;
    tick;
    gap[3] = 1'b1;
    tick;
    chk("t5_lock_ready_a", 32'(s_ready), 32'h8);
    tick;
    chk("t5_lock_ready_b", 32'(s_ready), 32'h8);
    gap[3] = 1'b0;
    drain("t5");
    check_log("t5");

    // async reset while FULL and locked
    m_ready = 1'b0;
    push(2, 8'h70, 1'b0);
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b1);
    tick;
    tick;
    tick;
    chk("t6_full_ready", 32'(s_ready), 32'd0);
    chk("t6_full_data", 32'(m_data), 32'h70);
    rstn = 1'b0;
    #1;
    chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_s_ready", 32'(s_ready), 32'd0);
    chk("t6_rst_m_data", 32'(m_data), 32'd0);
    clear_tx();
    xlog.delete();
    exp_q.delete();
    push(1, 8'h81, 1'b1);
    push(2, 8'h82, 1'b1);
    m_ready = 1'b1;
    tick;
    rstn = 1'b1;
    #1;
    chk("t6_first_grant", 32'(s_ready), 32'h2);
    expb(8'h81, 1'b1, 1);
    expb(8'h82, 1'b1, 2);
    drain("t6");
    check_log("t6");

    // randomized traffic: per-source order and beat count end to end
    npush = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      m_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        gap[i] = ($urandom % 8) == 0;
        if (txq[i].size() < 4 && ($urandom % 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            tx_t t;
            t = '{8'($urandom), j == len - 1};
            txq[i].push_back(t);
            rexp[i].push_back(t);
            npush++;
          end
        end
      end
    end
    drain("rand");
    chk("rand_count", 32'(xlog.size()), 32'(npush));
    foreach (xlog[j]) begin
      if (rexp[xlog[j].src].size() == 0) begin
        chk("rand_extra_beat", 32'(xlog[j]), 32'hFFFF);
      end else begin
        tx_t e;
        e = rexp[xlog[j].src].pop_front();
        chk("rand_src_order", 32'({xlog[j].data, xlog[j].last}), 32'(e));
      end
    end
    xlog.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
